paced_tx_fifo: RTL and testbench

Parametrised transmit FIFO that buffers result bytes and releases them to the UART transmitter at a programmable pace. It generalises the fixed 8-bit, 64-entry, fixed-interval transmit buffer. It adds configurable width, depth and interval, full/almost-full/level status, overflow protection, and a tx_busy back-pressure input from the UART. It sits between the result producer (counter/statistics logic) and the UART TX serialiser.

---
 rtl/paced_tx_fifo.sv | 118 +++++++++++
 tb/tb_paced_tx_fifo.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/paced_tx_fifo.sv
// Paced transmit FIFO: buffers words and hands them to the UART at most once per PACE_CYCLES.
// Optional PACED_FIFO_STATS_EN adds sticky overflow and a saturating drop counter.
module paced_tx_fifo #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 64,
  parameter int PACE_CYCLES = 26100,
  parameter int AF_MARGIN   = 4,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              tx_busy,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_en,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
`ifdef PACED_FIFO_STATS_EN
  output logic              overflow,
  output logic [15:0]       drop_cnt,
`endif
  output logic [AW:0]       level
);

  localparam int PW = (PACE_CYCLES > 1) ? $clog2(PACE_CYCLES) : 1;
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AF_LVL   = (AW+1)'(DEPTH - AF_MARGIN);
  localparam logic [PW-1:0] PACE_RLD = PW'(PACE_CYCLES - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic [PW-1:0]     pace_cnt_q, pace_cnt_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_ok, issue;

  // Flags come from the registered level, so a write while full is refused even if a read issues.
  always_comb begin
    empty       = (level_q == '0);
    full        = (level_q == FULL_LVL);
    almost_full = (level_q >= AF_LVL);
    wr_ok       = wr_en && !full;
    issue       = !empty && !tx_busy && (pace_cnt_q == '0);

    wr_ptr_d   = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = issue ? rd_ptr_q + AW'(1) : rd_ptr_q;
    data_out_d = issue ? mem[rd_ptr_q] : data_out_q;
    rd_en_d    = issue;

    level_d = level_q;
    case ({wr_ok, issue})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase

    pace_cnt_d = pace_cnt_q;
    if (issue)                 pace_cnt_d = PACE_RLD;
    else if (pace_cnt_q != '0) pace_cnt_d = pace_cnt_q - PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      pace_cnt_q <= '0;
      data_out_q <= '0;
      rd_en_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      pace_cnt_q <= pace_cnt_d;
      data_out_q <= data_out_d;
      rd_en_q    <= rd_en_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= data_in;
  end

  assign data_out = data_out_q;
  assign rd_en    = rd_en_q;
  assign level    = level_q;

`ifdef PACED_FIFO_STATS_EN
  logic        overflow_q, overflow_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        drop;

  always_comb begin
    drop       = wr_en && full;
    overflow_d = overflow_q | drop;
    drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_paced_tx_fifo.sv
// Scoreboard bench for paced_tx_fifo: pace-8 instance for latency/pacing/full/back-pressure/reset,
// pace-1 instance for back-to-back wrap-around streaming.
module tb_paced_tx_fifo;
  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, wr_en2, tx_busy;
  logic [7:0] data_in, data_in2;
  logic [7:0] data_out, data_out2;
  logic       rd_en, rd_en2, empty, empty2, full, full2, almost_full, almost_full2;
  logic [2:0] level, level2;
`ifdef PACED_FIFO_STATS_EN
  logic        overflow, overflow2;
  logic [15:0] drop_cnt, drop_cnt2;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int max_lvl2 = 0;
  int rd2_cnt = 0;
  int t0, tr;
  logic [7:0] exp_q[$];
  logic [7:0] exp2_q[$];
  int rd_times[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  paced_tx_fifo #(.DATA_W(8), .DEPTH(4), .PACE_CYCLES(8), .AF_MARGIN(1)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .tx_busy(tx_busy),
    .data_out(data_out), .rd_en(rd_en), .empty(empty), .full(full),
    .almost_full(almost_full),
`ifdef PACED_FIFO_STATS_EN
    .overflow(overflow), .drop_cnt(drop_cnt),
`endif
    .level(level));

  paced_tx_fifo #(.DATA_W(8), .DEPTH(4), .PACE_CYCLES(1), .AF_MARGIN(1)) u_dut_p1 (
    .clk(clk), .rst(rst), .wr_en(wr_en2), .data_in(data_in2), .tx_busy(1'b0),
    .data_out(data_out2), .rd_en(rd_en2), .empty(empty2), .full(full2),
    .almost_full(almost_full2),
`ifdef PACED_FIFO_STATS_EN
    .overflow(overflow2), .drop_cnt(drop_cnt2),
`endif
    .level(level2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rd_at(input int i);
    return (i < rd_times.size()) ? rd_times[i] : -1;
  endfunction

  // Only the pace-8 instance ever fills; no read can issue while it does.
  task automatic push_wr(input logic [7:0] v);
    data_in = v;
    wr_en   = 1'b1;
    if (exp_q.size() < 4) exp_q.push_back(v);
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && rd_en) begin
      rd_times.push_back(cyc);
      if (exp_q.size() == 0) chk("unexpected_rd", 32'd1, 32'd0);
      else chk("rd_data", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
    end
    if (!rst && rd_en2) begin
      rd2_cnt++;
      if (exp2_q.size() == 0) chk("unexpected_rd2", 32'd1, 32'd0);
      else chk("rd2_data", {24'd0, data_out2}, {24'd0, exp2_q.pop_front()});
    end
    if (int'(level2) > max_lvl2) max_lvl2 = int'(level2);
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; data_in = '0; tx_busy = 1'b0; wr_en2 = 1'b0; data_in2 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_level", level, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_empty2", empty2, 1);
`ifdef PACED_FIFO_STATS_EN
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
`endif

    // Single word: issue one edge after the write edge.
    rd_times.delete();
    push_wr(8'hA1);
    t0 = cyc;
    chk("t1_level_after_wr", level, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("t1_rd_count", rd_times.size(), 1);
    chk("t1_latency", rd_at(0), t0 + 1);
    chk("t1_level_end", level, 0);
    chk("t1_empty_end", empty, 1);

    // Three words: strobes 8 cycles apart.
    repeat (12) @(posedge clk);
    #1 rd_times.delete();
    push_wr(8'h10);
    t0 = cyc;
    push_wr(8'h11);
    push_wr(8'h12);
    repeat (25) @(posedge clk);
    #1;
    chk("t2_rd_count", rd_times.size(), 3);
    chk("t2_rd0", rd_at(0), t0 + 1);
    chk("t2_rd1", rd_at(1), t0 + 9);
    chk("t2_rd2", rd_at(2), t0 + 17);

    // Overfill while busy.
    tx_busy = 1'b1;
    rd_times.delete();
    for (int i = 1; i <= 6; i++) push_wr(8'(i));
    chk("t3_full", full, 1);
    chk("t3_level", level, 4);
    chk("t3_af", almost_full, 1);
    chk("t3_empty", empty, 0);
    chk("t3_no_rd_busy", rd_times.size(), 0);
`ifdef PACED_FIFO_STATS_EN
    chk("t3_overflow", overflow, 1);
    chk("t3_drop_cnt", drop_cnt, 2);
`endif
    tx_busy = 1'b0;
    tr = cyc;
    repeat (40) @(posedge clk);
    #1;
    chk("t3_rd_count", rd_times.size(), 4);
    chk("t3_rd0", rd_at(0), tr + 1);
    chk("t3_rd3", rd_at(3), tr + 25);
    chk("t3_sb_drained", exp_q.size(), 0);
    chk("t3_empty_end", empty, 1);

    // Pace-1 streaming through the pointer wrap.
    for (int i = 0; i < 10; i++) begin
      data_in2 = 8'(i);
      wr_en2   = 1'b1;
      exp2_q.push_back(8'(i));
      @(posedge clk);
      #1;
    end
    wr_en2 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("t4_rd_count", rd2_cnt, 10);
    chk("t4_sb_drained", exp2_q.size(), 0);
    chk("t4_max_level_le2", max_lvl2 <= 2, 1);
    chk("t4_empty", empty2, 1);

    // Back-pressure after first issue.
    repeat (10) @(posedge clk);
    #1 rd_times.delete();
    push_wr(8'h20);
    push_wr(8'h21);
    tx_busy = 1'b1;
    repeat (20) @(posedge clk);
    #1 tx_busy = 1'b0;
    tr = cyc;
    repeat (4) @(posedge clk);
    #1;
    chk("t5_rd_count", rd_times.size(), 2);
    chk("t5_rd1_on_release", rd_at(1), tr + 1);
    chk("t5_sb_drained", exp_q.size(), 0);

    // Reset between issues.
    repeat (10) @(posedge clk);
    #1;
    push_wr(8'h30);
    push_wr(8'h31);
    push_wr(8'h32);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    chk("t6_rd_en", rd_en, 0);
    chk("t6_level", level, 0);
    chk("t6_empty", empty, 1);
    chk("t6_data_out", data_out, 0);
`ifdef PACED_FIFO_STATS_EN
    chk("t6_overflow", overflow, 0);
    chk("t6_drop_cnt", drop_cnt, 0);
`endif
    rd_times.delete();
    push_wr(8'h55);
    t0 = cyc;
    repeat (12) @(posedge clk);
    #1;
    chk("t6_rd_count", rd_times.size(), 1);
    chk("t6_latency", rd_at(0), t0 + 1);
    chk("t6_data_hold", data_out, 8'h55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
